// File: rtl/up_gpio_ctrl.sv
// up_gpio_ctrl: sole uP-bus master for an up_gpio instance. Programs the
// tri-state and interrupt registers after reset, then services interrupts
// (ISR read, data read, ISR clear, event out) and forwards host words to
// GPIO_DATA. Every bus request is guarded by an ack timeout.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   INIT_TRI  | write GPIO_TRI = TRI_INIT
//   INIT_IER  | write IP_IER = 0x00000001
//   INIT_GIER | write GIER = 0x80000000, then init_done
//   IDLE      | wait for irq (first) or a host word
//   ISR_RD    | read IP_ISR into isr_q
//   DATA_RD   | read GPIO_DATA into m_evt_data
//   ISR_CLR   | write isr_q back to IP_ISR (toggle-on-write clear)
//   EVT       | present m_evt_data until m_evt_ready
//   WR_DATA   | write the buffered host word to GPIO_DATA
module up_gpio_ctrl #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter logic [31:0] TRI_INIT      = 32'hFFFFFFFF,
  parameter int          ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     up_rreq,
  input  logic                     up_rack,
  output logic [ADDRESS_WIDTH-1:0] up_raddr,
  input  logic [31:0]              up_rdata,
  output logic                     up_wreq,
  input  logic                     up_wack,
  output logic [ADDRESS_WIDTH-1:0] up_waddr,
  output logic [31:0]              up_wdata,
  input  logic                     irq,
  input  logic                     s_wr_valid,
  output logic                     s_wr_ready,
  input  logic [31:0]              s_wr_data,
  output logic                     m_evt_valid,
  input  logic                     m_evt_ready,
  output logic [31:0]              m_evt_data,
  output logic                     init_done,
  output logic                     err
);

  localparam logic [11:0] OFF_DATA = 12'h000;
  localparam logic [11:0] OFF_TRI  = 12'h004;
  localparam logic [11:0] OFF_GIER = 12'h11C;
  localparam logic [11:0] OFF_ISR  = 12'h120;
  localparam logic [11:0] OFF_IER  = 12'h128;

  localparam int             CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0]  TMO_LOAD = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    INIT_TRI, INIT_IER, INIT_GIER, IDLE, ISR_RD, DATA_RD, ISR_CLR, EVT, WR_DATA
  } state_t;

  state_t        state, state_n;
  logic          req_busy, ack, tmo, done, raise, accept;
  logic          bus_state, rd_state;
  logic          pend, pend_n;
  logic [CW-1:0] tmo_cnt;
  logic [11:0]   bus_off;
  logic [31:0]   bus_wdata, rd_val, isr_q, wr_data_q;

  // A request is finished either by an ack or by the timeout counter running out.
  assign req_busy = up_rreq | up_wreq;
  assign ack      = (up_rreq & up_rack) | (up_wreq & up_wack);
  assign tmo      = req_busy & ~ack & (tmo_cnt == '0);
  assign done     = ack | tmo;
  assign raise    = bus_state & ~req_busy;
  assign accept   = (state == IDLE) & s_wr_valid & s_wr_ready;
  assign rd_val   = (up_rreq & up_rack) ? up_rdata : 32'h0;

  // Address, write data and direction of the transaction owned by each state.
  always_comb begin
    bus_off   = OFF_DATA;
    bus_wdata = 32'h0;
    bus_state = 1'b1;
    rd_state  = 1'b0;
    case (state)
      INIT_TRI:  begin bus_off = OFF_TRI;  bus_wdata = TRI_INIT;     end
      INIT_IER:  begin bus_off = OFF_IER;  bus_wdata = 32'h00000001; end
      INIT_GIER: begin bus_off = OFF_GIER; bus_wdata = 32'h80000000; end
      ISR_RD:    begin bus_off = OFF_ISR;  rd_state  = 1'b1;         end
      DATA_RD:   begin bus_off = OFF_DATA; rd_state  = 1'b1;         end
      ISR_CLR:   begin bus_off = OFF_ISR;  bus_wdata = isr_q;        end
      WR_DATA:   begin bus_off = OFF_DATA; bus_wdata = wr_data_q;    end
      default:   bus_state = 1'b0;
    endcase
  end

  // Next-state logic. A host word accepted on the same edge that irq wins
  // is parked in wr_data_q and written once interrupt service is over.
  always_comb begin
    state_n = state;
    pend_n  = pend | accept;
    case (state)
      INIT_TRI:  if (done) state_n = INIT_IER;
      INIT_IER:  if (done) state_n = INIT_GIER;
      INIT_GIER: if (done) state_n = IDLE;
      IDLE: begin
        if (irq)                  state_n = ISR_RD;
        else if (pend | accept)   state_n = WR_DATA;
      end
      ISR_RD:    if (done) state_n = DATA_RD;
      DATA_RD:   if (done) state_n = ISR_CLR;
      ISR_CLR:   if (done) state_n = EVT;
      EVT:       if (m_evt_ready) state_n = IDLE;
      WR_DATA: begin
        if (done) begin
          state_n = IDLE;
          pend_n  = 1'b0;
        end
      end
      default:   state_n = INIT_TRI;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= INIT_TRI;
    else       state <= state_n;
  end

  // Bus request generation and ack-timeout down-counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_rreq  <= 1'b0;
      up_wreq  <= 1'b0;
      up_raddr <= '0;
      up_waddr <= '0;
      up_wdata <= 32'h0;
      tmo_cnt  <= '0;
    end else if (raise) begin
      tmo_cnt <= TMO_LOAD;
      if (rd_state) begin
        up_rreq  <= 1'b1;
        up_raddr <= ADDRESS_WIDTH'(bus_off);
      end else begin
        up_wreq  <= 1'b1;
        up_waddr <= ADDRESS_WIDTH'(bus_off);
        up_wdata <= bus_wdata;
      end
    end else if (req_busy) begin
      if (done) begin
        up_rreq <= 1'b0;
        up_wreq <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end

  // Read-data capture, host word buffer, status flags and stream handshakes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      isr_q       <= 32'h0;
      m_evt_data  <= 32'h0;
      wr_data_q   <= 32'h0;
      pend        <= 1'b0;
      err         <= 1'b0;
      init_done   <= 1'b0;
      s_wr_ready  <= 1'b0;
      m_evt_valid <= 1'b0;
    end else begin
      if (state == ISR_RD && done)    isr_q      <= rd_val;
      if (state == DATA_RD && done)   m_evt_data <= rd_val;
      if (accept)                     wr_data_q  <= s_wr_data;
      if (tmo)                        err        <= 1'b1;
      if (state == INIT_GIER && done) init_done  <= 1'b1;
      pend        <= pend_n;
      s_wr_ready  <= (state_n == IDLE) & ~irq & ~pend_n;
      m_evt_valid <= (state_n == EVT);
    end
  end

endmodule

// File: tb/tb_up_gpio_ctrl.sv
// Bench for up_gpio_ctrl: a behavioural up_gpio slave with a transaction
// log, compared against expected transaction lists built from the
// controller's register-level behaviour.
module tb_up_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        up_rreq, up_rack, up_wreq, up_wack;
  logic [31:0] up_raddr, up_rdata, up_waddr, up_wdata;
  logic        irq, s_wr_valid, s_wr_ready, m_evt_valid, m_evt_ready;
  logic [31:0] s_wr_data, m_evt_data;
  logic        init_done, err;

  always #5 clk = ~clk;

  up_gpio_ctrl #(.ADDRESS_WIDTH(32), .TRI_INIT(32'hFFFFFFFF), .ACK_TIMEOUT(255)) dut (
    .clk(clk), .rstn(rstn),
    .up_rreq(up_rreq), .up_rack(up_rack), .up_raddr(up_raddr), .up_rdata(up_rdata),
    .up_wreq(up_wreq), .up_wack(up_wack), .up_waddr(up_waddr), .up_wdata(up_wdata),
    .irq(irq), .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_data(s_wr_data),
    .m_evt_valid(m_evt_valid), .m_evt_ready(m_evt_ready), .m_evt_data(m_evt_data),
    .init_done(init_done), .err(err)
  );

  // kind: 0 = read, 1 = write, 2 = event accepted; flags = {init_done, err} at the time
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  flags;
  } txn_t;

  txn_t log_q[$];
  txn_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] isr_val = 32'h1;
  logic [31:0] gpio_val = 32'h0;
  bit          stall_isr = 0, stall_ier = 0, rand_ready = 0, ready_req = 1;
  int          spur_req = 0, spur_done = 0;
  int          evt_hi = 0, hs_cnt = 0, isr_rd_hi = 0, viol = 0;
  logic        prev_rreq = 0, prev_wreq = 0, prev_cmpl = 0;
  logic [31:0] prev_raddr = 0, prev_waddr = 0, prev_wdata = 0;

  // Slave, event consumer and bus monitor, all acting on the falling edge.
  always @(negedge clk) begin
    txn_t t;
    if (!rstn) begin
      up_rack = 1'b0; up_wack = 1'b0; up_rdata = 32'h0;
      m_evt_ready = ready_req;
      prev_rreq = 0; prev_wreq = 0; prev_cmpl = 0;
    end else begin
      if (spur_req != spur_done && !up_rreq && !up_wreq) begin
        up_rack = 1'b1; up_wack = 1'b1; spur_done = spur_req;
      end else begin
        up_rack = up_rreq & ~up_rack & ~(stall_isr && up_raddr == 32'h120);
        up_wack = up_wreq & ~up_wack & ~(stall_ier && up_waddr == 32'h128);
      end
      if (up_rack)
        up_rdata = (up_raddr == 32'h120) ? isr_val : (up_raddr == 32'h0) ? gpio_val : 32'h0BAD0BAD;
      m_evt_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_req;
      t.flags = {init_done, err};
      if (up_rreq && up_rack) begin t.kind = 0; t.addr = up_raddr; t.data = up_rdata; log_q.push_back(t); end
      if (up_wreq && up_wack) begin t.kind = 1; t.addr = up_waddr; t.data = up_wdata; log_q.push_back(t); end
      if (m_evt_valid && m_evt_ready) begin t.kind = 2; t.addr = 0; t.data = m_evt_data; log_q.push_back(t); end
      if (m_evt_valid) evt_hi++;
      if (s_wr_valid && s_wr_ready) hs_cnt++;
      if (up_rreq && up_raddr == 32'h120) isr_rd_hi++;
      if (up_rreq && up_wreq) viol++;
      if ((prev_rreq && up_wreq) || (prev_wreq && up_rreq)) viol++;
      if (prev_cmpl && (up_rreq || up_wreq)) viol++;
      if (prev_rreq && up_rreq && up_raddr !== prev_raddr) viol++;
      if (prev_wreq && up_wreq && (up_waddr !== prev_waddr || up_wdata !== prev_wdata)) viol++;
      prev_cmpl  = (up_rreq && up_rack) || (up_wreq && up_wack);
      prev_rreq  = up_rreq;  prev_wreq  = up_wreq;
      prev_raddr = up_raddr; prev_waddr = up_waddr; prev_wdata = up_wdata;
    end
  end

  // Reference behaviour: the register transactions each operation produces.
  task automatic model_init();
    txn_t t;
    t.flags = 0;
    t.kind = 1; t.addr = 32'h004; t.data = 32'hFFFFFFFF; exp_q.push_back(t);
    t.kind = 1; t.addr = 32'h128; t.data = 32'h00000001; exp_q.push_back(t);
    t.kind = 1; t.addr = 32'h11C; t.data = 32'h80000000; exp_q.push_back(t);
  endtask

  task automatic model_irq(input logic [31:0] isr, input logic [31:0] gpio, input bit isr_lost);
    txn_t t;
    t.flags = 0;
    if (!isr_lost) begin t.kind = 0; t.addr = 32'h120; t.data = isr; exp_q.push_back(t); end
    t.kind = 0; t.addr = 32'h000; t.data = gpio; exp_q.push_back(t);
    t.kind = 1; t.addr = 32'h120; t.data = isr_lost ? 32'h0 : isr; exp_q.push_back(t);
    t.kind = 2; t.addr = 32'h000; t.data = gpio; exp_q.push_back(t);
  endtask

  task automatic model_write(input logic [31:0] d);
    txn_t t;
    t.flags = 0; t.kind = 1; t.addr = 32'h000; t.data = d; exp_q.push_back(t);
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    int c = 0;
    while (log_q.size() < n && c < budget) begin @(negedge clk); c++; end
    ok = (log_q.size() >= n);
  endtask

  task automatic send_word(input logic [31:0] d, output bit ok);
    int c = 0;
    @(posedge clk); #1;
    s_wr_valid = 1'b1; s_wr_data = d;
    do begin @(negedge clk); c++; end while (!s_wr_ready && c < 100);
    ok = s_wr_ready;
    @(posedge clk); #1;
    s_wr_valid = 1'b0;
  endtask

  task automatic pulse_irq();
    @(posedge clk); #1 irq = 1'b1;
    @(posedge clk); #1 irq = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; irq = 1'b0; s_wr_valid = 1'b0; s_wr_data = 32'h0;
    #32;
    n_cmp++;
    if ({up_rreq, up_wreq, up_raddr, up_waddr, up_wdata, s_wr_ready, m_evt_valid,
         m_evt_data, init_done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rreq=%b wreq=%b raddr=%h waddr=%h wdata=%h rdy=%b vld=%b evt=%h done=%b err=%b, want all 0",
               up_rreq, up_wreq, up_raddr, up_waddr, up_wdata, s_wr_ready, m_evt_valid, m_evt_data, init_done, err);
    end
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_init();
    int base = 0;
    bit ok;
    exp_q.delete(); model_init();
    wait_log(3, 60, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL init_wait: got %0d txns, want 3", log_q.size()); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (log_q.size() != 3) begin n_fail++; $display("FAIL init_quiet: got %0d txns, want 3", log_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (base + i >= log_q.size()) begin n_fail++; $display("FAIL init_txn%0d: missing, want %0d %h %h", i, exp_q[i].kind, exp_q[i].addr, exp_q[i].data); end
      else if (log_q[base+i].kind != exp_q[i].kind || log_q[base+i].addr !== exp_q[i].addr || log_q[base+i].data !== exp_q[i].data || log_q[base+i].flags !== 2'b00) begin
        n_fail++;
        $display("FAIL init_txn%0d: got %0d %h %h flags=%b, want %0d %h %h flags=00", i, log_q[base+i].kind, log_q[base+i].addr,
                 log_q[base+i].data, log_q[base+i].flags, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
    n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b, want 1", init_done); end
    n_cmp++; if (s_wr_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b, want 1", s_wr_ready); end
  endtask

  task automatic test_irq();
    int base, evt0, lat;
    bit ok;
    isr_val = 32'h1; gpio_val = 32'hDEADBEEF; ready_req = 1;
    base = log_q.size(); evt0 = evt_hi;
    exp_q.delete(); model_irq(32'h1, 32'hDEADBEEF, 0);
    @(posedge clk); #1 irq = 1'b1;
    fork begin @(posedge clk); #1 irq = 1'b0; end join_none
    lat = 0;
    while (!m_evt_valid && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL irq_latency: got %0d cycles, want 8", lat); end
    wait_log(base + 4, 60, ok);
    repeat (5) @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (base + i >= log_q.size()) begin n_fail++; $display("FAIL irq_txn%0d: missing, want %0d %h %h", i, exp_q[i].kind, exp_q[i].addr, exp_q[i].data); end
      else if (log_q[base+i].kind != exp_q[i].kind || log_q[base+i].addr !== exp_q[i].addr || log_q[base+i].data !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL irq_txn%0d: got %0d %h %h, want %0d %h %h", i, log_q[base+i].kind, log_q[base+i].addr, log_q[base+i].data,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
    n_cmp++; if (evt_hi - evt0 != 1) begin n_fail++; $display("FAIL irq_evt_width: got %0d cycles, want 1", evt_hi - evt0); end
  endtask

  task automatic test_output();
    int base, hs0;
    bit ok, ok2;
    base = log_q.size(); hs0 = hs_cnt;
    exp_q.delete(); model_write(32'hBABEDEAD);
    send_word(32'hBABEDEAD, ok);
    wait_log(base + 1, 40, ok2);
    repeat (5) @(negedge clk);
    n_cmp++; if (!ok || hs_cnt - hs0 != 1) begin n_fail++; $display("FAIL out_handshake: got %0d cycles, want 1", hs_cnt - hs0); end
    n_cmp++;
    if (log_q.size() != base + 1 || log_q[base].kind != 1 || log_q[base].addr !== 32'h0 || log_q[base].data !== exp_q[0].data) begin
      n_fail++; $display("FAIL out_write: got %0d txns, want one write 000<-%h", log_q.size() - base, exp_q[0].data);
    end
  endtask

  task automatic test_contention();
    int base, good, c;
    bit ok, ok2;
    logic [31:0] w;
    isr_val = $urandom | 32'h1; gpio_val = $urandom; w = $urandom;
    base = log_q.size();
    exp_q.delete(); model_irq(isr_val, gpio_val, 0); model_write(w);
    @(posedge clk); #1 ready_req = 0;
    @(negedge clk);
    fork
      send_word(w, ok);
      pulse_irq();
    join
    c = 0;
    while (!m_evt_valid && c < 40) begin @(negedge clk); c++; end
    good = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_evt_valid === 1'b1 && s_wr_ready === 1'b0 && m_evt_data === gpio_val) good++;
      @(negedge clk);
    end
    n_cmp++; if (good != 20) begin n_fail++; $display("FAIL cont_hold: got %0d good cycles, want 20", good); end
    ready_req = 1;
    wait_log(base + exp_q.size(), 80, ok2);
    repeat (5) @(negedge clk);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL cont_accept: host word not accepted, want accepted"); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (base + i >= log_q.size()) begin n_fail++; $display("FAIL cont_txn%0d: missing, want %0d %h %h", i, exp_q[i].kind, exp_q[i].addr, exp_q[i].data); end
      else if (log_q[base+i].kind != exp_q[i].kind || log_q[base+i].addr !== exp_q[i].addr || log_q[base+i].data !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL cont_txn%0d: got %0d %h %h, want %0d %h %h", i, log_q[base+i].kind, log_q[base+i].addr, log_q[base+i].data,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, op;
    bit ok, ok2;
    logic [31:0] w;
    base = log_q.size();
    exp_q.delete();
    rand_ready = 1;
    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(0, 2);
      isr_val = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      gpio_val = $urandom; w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1 spur_req++;
        repeat (2) @(negedge clk);
      end
      if (op != 1) model_irq(isr_val, gpio_val, 0);
      if (op != 0) model_write(w);
      case (op)
        0: pulse_irq();
        1: send_word(w, ok);
        default: fork send_word(w, ok); pulse_irq(); join
      endcase
      wait_log(base + exp_q.size(), 300, ok2);
      repeat (4) @(negedge clk);
    end
    rand_ready = 0;
    n_cmp++; if (log_q.size() != base + exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d txns, want %0d", log_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (base + i >= log_q.size()) begin n_fail++; $display("FAIL b2b_txn%0d: missing, want %0d %h %h", i, exp_q[i].kind, exp_q[i].addr, exp_q[i].data); end
      else if (log_q[base+i].kind != exp_q[i].kind || log_q[base+i].addr !== exp_q[i].addr || log_q[base+i].data !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL b2b_txn%0d: got %0d %h %h, want %0d %h %h", i, log_q[base+i].kind, log_q[base+i].addr, log_q[base+i].data,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_timeout();
    int base, rd0;
    bit ok;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_before: got %b, want 0", err); end
    gpio_val = $urandom; isr_val = 32'h5; ready_req = 1; stall_isr = 1;
    base = log_q.size(); rd0 = isr_rd_hi;
    exp_q.delete(); model_irq(isr_val, gpio_val, 1);
    pulse_irq();
    wait_log(base + 3, 600, ok);
    repeat (5) @(negedge clk);
    stall_isr = 0;
    n_cmp++; if (isr_rd_hi - rd0 != 255) begin n_fail++; $display("FAIL tmo_rreq_len: got %0d cycles, want 255", isr_rd_hi - rd0); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b, want 1", err); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (base + i >= log_q.size()) begin n_fail++; $display("FAIL tmo_txn%0d: missing, want %0d %h %h", i, exp_q[i].kind, exp_q[i].addr, exp_q[i].data); end
      else if (log_q[base+i].kind != exp_q[i].kind || log_q[base+i].addr !== exp_q[i].addr || log_q[base+i].data !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL tmo_txn%0d: got %0d %h %h, want %0d %h %h", i, log_q[base+i].kind, log_q[base+i].addr, log_q[base+i].data,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, c;
    bit ok;
    stall_ier = 1;
    @(posedge clk); #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    c = 0;
    while (!(up_wreq && up_waddr == 32'h128) && c < 60) begin @(negedge clk); c++; end
    n_cmp++; if (c >= 60) begin n_fail++; $display("FAIL mid_reach_ier: wreq to 128 not seen, want seen"); end
    #1 rstn = 1'b0;
    #1;
    n_cmp++;
    if (up_wreq !== 1'b0 || up_rreq !== 1'b0) begin n_fail++; $display("FAIL mid_req_drop: wreq=%b rreq=%b, want 0 0", up_wreq, up_rreq); end
    n_cmp++;
    if (init_done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_flags: done=%b err=%b, want 0 0", init_done, err); end
    stall_ier = 0;
    repeat (2) @(posedge clk);
    base = log_q.size();
    #1 rstn = 1'b1;
    exp_q.delete(); model_init();
    wait_log(base + 3, 60, ok);
    repeat (10) @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (base + i >= log_q.size()) begin n_fail++; $display("FAIL mid_txn%0d: missing, want %0d %h %h", i, exp_q[i].kind, exp_q[i].addr, exp_q[i].data); end
      else if (log_q[base+i].kind != exp_q[i].kind || log_q[base+i].addr !== exp_q[i].addr || log_q[base+i].data !== exp_q[i].data || log_q[base+i].flags !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_txn%0d: got %0d %h %h flags=%b, want %0d %h %h flags=00", i, log_q[base+i].kind, log_q[base+i].addr,
                 log_q[base+i].data, log_q[base+i].flags, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
    n_cmp++;
    if (init_done !== 1'b1 || err !== 1'b0 || log_q.size() != base + 3) begin
      n_fail++; $display("FAIL mid_reinit: done=%b err=%b txns=%0d, want 1 0 3", init_done, err, log_q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_irq();
    test_output();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    n_cmp++;
    if (viol != 0) begin n_fail++; $display("FAIL bus_protocol: got %0d violations, want 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
